// File: rtl/ps2_keyboard_if.sv
// PS/2 keyboard front-end bundle: raw PS/2 lines toward the receiver,
// decoded key code and byte-level status back toward the consumer.
interface ps2_keyboard_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] out;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_error;

    modport master (
        output ps2_clk, ps2_data,
        input  out, rx_byte, rx_valid, rx_error
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output out, rx_byte, rx_valid, rx_error
    );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 receiver: synchronises the device lines, frames 11-bit words,
// decodes E0/F0 make/break sequences and holds the current Hack key code.
module ps2_keyboard #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic         clock,
    input  logic         reset,
    ps2_keyboard_if.slave bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic                   par_ok_q;
    logic [TW-1:0]          tmo_q;
    logic [7:0]             rx_byte_q;
    logic                   rx_valid_q, rx_error_q;
    logic                   ext_q, brk_q;
    logic [7:0]             key_q;
    logic                   fall, din;
    logic [8:0]             map_res;

    assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign din  = dat_sync_q[SYNC_STAGES-1];

    // Returns {hit, code}; ext selects the E0-prefixed table.
    function automatic logic [8:0] key_map(input logic ext, input logic [7:0] sc);
        logic [7:0] c;
        logic       h;
        c = '0;
        h = 1'b1;
        case ({ext, sc})
            9'h01C: c = 8'h41;  9'h032: c = 8'h42;  9'h021: c = 8'h43;  9'h023: c = 8'h44;
            9'h024: c = 8'h45;  9'h02B: c = 8'h46;  9'h034: c = 8'h47;  9'h033: c = 8'h48;
            9'h043: c = 8'h49;  9'h03B: c = 8'h4A;  9'h042: c = 8'h4B;  9'h04B: c = 8'h4C;
            9'h03A: c = 8'h4D;  9'h031: c = 8'h4E;  9'h044: c = 8'h4F;  9'h04D: c = 8'h50;
            9'h015: c = 8'h51;  9'h02D: c = 8'h52;  9'h01B: c = 8'h53;  9'h02C: c = 8'h54;
            9'h03C: c = 8'h55;  9'h02A: c = 8'h56;  9'h01D: c = 8'h57;  9'h022: c = 8'h58;
            9'h035: c = 8'h59;  9'h01A: c = 8'h5A;
            9'h045: c = 8'h30;  9'h016: c = 8'h31;  9'h01E: c = 8'h32;  9'h026: c = 8'h33;
            9'h025: c = 8'h34;  9'h02E: c = 8'h35;  9'h036: c = 8'h36;  9'h03D: c = 8'h37;
            9'h03E: c = 8'h38;  9'h046: c = 8'h39;
            9'h029: c = 8'd32;  9'h05A: c = 8'd128; 9'h066: c = 8'd129; 9'h076: c = 8'd140;
            9'h16B: c = 8'd130; 9'h175: c = 8'd131; 9'h174: c = 8'd132; 9'h172: c = 8'd133;
            9'h16C: c = 8'd134; 9'h169: c = 8'd135; 9'h17D: c = 8'd136; 9'h17A: c = 8'd137;
            9'h170: c = 8'd138; 9'h171: c = 8'd139;
            9'h005: c = 8'd141; 9'h006: c = 8'd142; 9'h004: c = 8'd143; 9'h00C: c = 8'd144;
            9'h003: c = 8'd145; 9'h00B: c = 8'd146; 9'h083: c = 8'd147; 9'h00A: c = 8'd148;
            9'h001: c = 8'd149; 9'h009: c = 8'd150; 9'h078: c = 8'd151; 9'h007: c = 8'd152;
            default: h = 1'b0;
        endcase
        return {h, c};
    endfunction

    always_comb map_res = key_map(ext_q, rx_byte_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            tmo_q      <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_q      <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;

            if (state_q == IDLE || fall) tmo_q <= '0;
            else                         tmo_q <= tmo_q + TW'(1);

            // An edge arriving in the expiry cycle is processed instead of timing out.
            if (fall) begin
                case (state_q)
                    IDLE: if (!din) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                    DATA: begin
                        shift_q   <= {din, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_ok_q <= ^{shift_q, din};
                        state_q  <= STOP;
                    end
                    STOP: begin
                        if (din && par_ok_q) begin
                            rx_byte_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_error_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
                rx_error_q <= 1'b1;
                state_q    <= IDLE;
            end

            if (rx_valid_q) begin
                if (rx_byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (rx_byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    if (map_res[8]) begin
                        if (!brk_q)                    key_q <= map_res[7:0];
                        else if (map_res[7:0] == key_q) key_q <= '0;
                    end
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
        end
    end

    assign bus.out      = {8'h00, key_q};
    assign bus.rx_byte  = rx_byte_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_error = rx_error_q;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-banged PS/2 frames, a byte scoreboard
// fed at send time, and key-code checks after each frame.
module tb_ps2_keyboard;
    localparam int HALF = 10;
    localparam int TMO  = 400;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ps2_keyboard_if bus ();

    ps2_keyboard #(.SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         n_valid = 0;
    int         n_err   = 0;
    logic [7:0] sbq[$];
    logic [7:0] sb_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (bus.rx_valid === 1'b1) begin
                n_valid++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $error("FAIL sb_unexpected: observed byte %0h expected none", bus.rx_byte);
                end else begin
                    sb_exp = sbq.pop_front();
                    chk("sb_byte", 32'(bus.rx_byte), 32'(sb_exp));
                end
            end
            if (bus.rx_error === 1'b1) n_err++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            cyc(HALF);
            bus.ps2_clk = 1'b0;
            cyc(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic send_ok(input logic [7:0] b);
        sbq.push_back(b);
        send(b, 1'b0, 1'b0, 11);
    endtask

    typedef struct { logic [7:0] sc; logic [15:0] code; } kv_t;
    kv_t kt[$] = '{'{8'h45, 16'h0030}, '{8'h16, 16'h0031}, '{8'h46, 16'h0039},
                   '{8'h29, 16'd32},   '{8'h5A, 16'd128},  '{8'h66, 16'd129},
                   '{8'h76, 16'd140},  '{8'h05, 16'd141},  '{8'h83, 16'd147},
                   '{8'h07, 16'd152},  '{8'h1A, 16'h005A}, '{8'h32, 16'h0042}};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset        = 1'b0;
        cyc(3);
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_byte", 32'(bus.rx_byte), 0);
        chk("rst_valid", 32'(bus.rx_valid), 0);
        chk("rst_error", 32'(bus.rx_error), 0);
        reset = 1'b1;
        cyc(5);

        // Reset in the middle of a frame.
        send(8'h1C, 1'b0, 1'b0, 5);
        reset = 1'b0;
        cyc(3);
        chk("midrst_out", 32'(bus.out), 0);
        reset = 1'b1;
        cyc(3);
        v0 = n_valid;
        send_ok(8'h1C);
        chk("after_rst_A", 32'(bus.out), 32'h41);
        chk("after_rst_vcnt", n_valid - v0, 1);

        // Make then break of A.
        v0 = n_valid;
        send_ok(8'h1C);
        chk("make_A", 32'(bus.out), 32'h41);
        send_ok(8'hF0);
        chk("f0_hold", 32'(bus.out), 32'h41);
        send_ok(8'h1C);
        chk("break_A", 32'(bus.out), 0);
        chk("brk_vcnt", n_valid - v0, 3);

        // Extended up-arrow make/break.
        send_ok(8'hE0); send_ok(8'h75);
        chk("make_up", 32'(bus.out), 32'd131);
        send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
        chk("break_up", 32'(bus.out), 0);

        // Plain 6B is unmapped; extended 1C is unmapped.
        send_ok(8'h1C);
        v0 = n_valid;
        send_ok(8'h6B);
        chk("plain_6B", 32'(bus.out), 32'h41);
        chk("plain_6B_v", n_valid - v0, 1);
        send_ok(8'hE0); send_ok(8'h1C);
        chk("ext_1C", 32'(bus.out), 32'h41);
        send_ok(8'h1A);
        chk("flags_clear", 32'(bus.out), 32'h5A);

        // Parity and stop errors.
        send_ok(8'h32);
        v0 = n_valid; e0 = n_err;
        send(8'h1C, 1'b1, 1'b0, 11);
        chk("par_out", 32'(bus.out), 32'h42);
        chk("par_err", n_err - e0, 1);
        chk("par_v", n_valid - v0, 0);
        send(8'h1C, 1'b0, 1'b1, 11);
        chk("stop_out", 32'(bus.out), 32'h42);
        chk("stop_err", n_err - e0, 2);
        chk("stop_v", n_valid - v0, 0);

        // Timeout after four bits.
        e0 = n_err;
        send(8'h1C, 1'b0, 1'b0, 4);
        cyc(TMO - 3 * HALF);
        chk("tmo_early", n_err - e0, 0);
        cyc(3 * HALF + 20);
        chk("tmo_err", n_err - e0, 1);
        send_ok(8'h29);
        chk("tmo_space", 32'(bus.out), 32'd32);

        // Rollover: break of a key not held leaves the new key.
        send_ok(8'h1C);
        chk("roll_A", 32'(bus.out), 32'h41);
        send_ok(8'h32);
        chk("roll_B", 32'(bus.out), 32'h42);
        send_ok(8'hF0); send_ok(8'h1C);
        chk("roll_hold", 32'(bus.out), 32'h42);

        foreach (kt[i]) begin
            send_ok(kt[i].sc);
            chk($sformatf("tbl_%02h", kt[i].sc), 32'(bus.out), 32'(kt[i].code));
        end

        cyc(10);
        chk("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- Keyboard front end. Receives PS/2 scan-code set 2 frames, decodes make/break sequences into Hack key codes, and holds the current key code.
- Sits directly upstream of the Memory keyboard slot (address 0x6000); `out` drives that slot's 16-bit read data.
- `out` is 0 when no mapped key is held.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the ps2_clk/ps2_data synchronizers (minimum 2).
- TIMEOUT, 50000, clock cycles without a PS/2 falling edge before a partial frame is discarded.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the device; asynchronous to clock.
- ps2_data  in  1  raw PS/2 data; asynchronous to clock.
- out  out  16  current Hack key code; bits [15:8] are always 0.
- rx_byte  out  8  last correctly framed byte.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- rx_error  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While reset=0: out=0, rx_byte=0, rx_valid=0, rx_error=0, FSM=IDLE, ext/brk flags=0, timeout counter=0, synchronizers load 1.
  - Reset mid-frame discards the partial frame.
- Synchronizer and edge detect:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge is synchronized clk previous=1, current=0.
  - Data is sampled only on a falling-edge cycle.
- Frame format: 11 bits, LSB first — start(0), d0..d7, parity (odd), stop(1).
- FSM transitions (all on falling edges):
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE, no error.
  - DATA: shift data into bit 7 of the shift register (right shift). After the 8th bit -> PARITY.
  - PARITY: check that the count of ones over the 8 data bits plus the parity bit is odd; latch pass/fail -> STOP.
  - STOP: if data=1 and parity passed -> rx_byte=shift register, rx_valid=1 in the following cycle, then decode. Otherwise rx_error=1 and nothing is decoded. Either way -> IDLE.
- Timeout:
  - In any non-IDLE state, the counter increments each cycle and clears on every falling edge.
  - Counter reaching TIMEOUT-1 -> rx_error=1, IDLE, byte discarded.
  - A falling edge in the same cycle as expiry wins: the edge is processed and there is no timeout.
- Decode, applied to each valid byte in the cycle after rx_valid:
  - 0xE0 -> ext=1. 0xF0 -> brk=1. Neither updates out.
  - Any other byte: map {ext, byte} through the key table.
    - brk=0 (make) and mapped -> out=code.
    - brk=1 (break) and mapped code == out -> out=0. Break of a key other than the one held leaves out unchanged.
    - Unmapped -> out unchanged.
    - ext and brk both clear after any non-prefix byte, mapped or not.
  - Auto-repeat make codes rewrite the same value (no visible change).
- Key table; all others unmapped:
  - Letters A–Z map to 0x41–0x5A, no shift handling (e.g. 0x1C->0x41 'A', 0x32->0x42, 0x1A->0x5A).
  - Digits: 0x45->0x30; 0x16,1E,26,25,2E,36,3D,3E,46 -> 0x31–0x39.
  - Space 0x29->32. Enter 0x5A->128. Backspace 0x66->129. Esc 0x76->140.
  - Extended: E0 6B->130 (left), E0 75->131 (up), E0 74->132 (right), E0 72->133 (down), E0 6C->134 (home), E0 69->135 (end), E0 7D->136 (pgup), E0 7A->137 (pgdn), E0 70->138 (ins), E0 71->139 (del).
  - F1–F12: 0x05,06,04,0C,03,0B,83,0A,01,09,78,07 -> 141–152.
  - The ext flag selects between the plain and extended tables: plain 0x6B (keypad 4) is unmapped.

Test Plan:
- Reset low mid-frame (after 5 bits), then release; send a valid frame for 0x1C -> out=0 during reset; after release out=0x0041 and rx_valid pulses once.
- Send 0x1C, then F0 1C -> out goes 0x0041, then 0x0000 after the 1C that follows F0; rx_valid pulses 3 times.
- Send E0 75 then E0 F0 75 -> out=131, then 0. Send plain 0x6B -> out unchanged and rx_valid pulses.
- Frame 0x1C with the parity bit inverted -> rx_error pulses, rx_valid stays 0, out unchanged. Frame with stop=0 -> same result.
- Stop ps2_clk after 4 bits for TIMEOUT cycles -> rx_error pulses at expiry; the next clean frame 0x29 gives out=32.
- Make 0x1C, make 0x32, break 0x1C (F0 1C) -> out=0x41, then 0x42, and stays 0x42.
